// File: rtl/ff_layer_sequencer_pkg.sv
// Shared types and helpers for the feed-forward layer sequencer.
package ff_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Widest packed size table the helper accepts; callers zero-extend into it.
  localparam int SIZES_MAX_W = 256;

  // Returns entry idx (aw bits wide, entry 0 in the LSBs) of a packed size table.
  function automatic logic [15:0] layer_size(input logic [SIZES_MAX_W-1:0] sizes,
                                             input int idx, input int aw);
    logic [15:0] mask;
    mask = 16'((32'd1 << aw) - 32'd1);
    return 16'(sizes >> (idx * aw)) & mask;
  endfunction

endpackage

// File: rtl/ff_layer_sequencer_if.sv
// Control/engine bus of ff_layer_sequencer; o_cycle_count exists only with FF_SEQ_PERF_CNT_EN.
interface ff_layer_sequencer_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int BUF_W         = 2
);
  import ff_seq_pkg::*;

  // Request handshake: i_valid is a 1-cycle pass request. It is accepted whenever
  // o_ready is high (no request pending); a request arriving while o_ready is low
  // is dropped. o_valid is a 1-cycle completion pulse with no back-pressure.
  logic                     i_valid;
  logic                     i_abort;
  logic                     i_layer_done;
  logic                     o_ready;
  logic                     o_busy;
  logic                     o_layer_start;
  logic [BUF_W-1:0]         o_layer_idx;
  logic [ADDRESS_WIDTH-1:0] o_num_in;
  logic [ADDRESS_WIDTH-1:0] o_num_out;
  logic                     o_act_en;
  logic [BUF_W-1:0]         o_src_buf;
  logic [BUF_W-1:0]         o_dst_buf;
  logic                     o_valid;
  state_t                   dbg_state;
`ifdef FF_SEQ_PERF_CNT_EN
  logic [31:0]              o_cycle_count;
`endif

  modport master (
    output i_valid, i_abort, i_layer_done,
    input  o_ready, o_busy, o_layer_start, o_layer_idx, o_num_in, o_num_out,
           o_act_en, o_src_buf, o_dst_buf, o_valid, dbg_state
`ifdef FF_SEQ_PERF_CNT_EN
           , o_cycle_count
`endif
  );

  modport slave (
    input  i_valid, i_abort, i_layer_done,
    output o_ready, o_busy, o_layer_start, o_layer_idx, o_num_in, o_num_out,
           o_act_en, o_src_buf, o_dst_buf, o_valid, dbg_state
`ifdef FF_SEQ_PERF_CNT_EN
           , o_cycle_count
`endif
  );

endinterface

// File: rtl/ff_layer_sequencer_perf_counter.sv
// Saturating pass-duration counter, built only when FF_SEQ_PERF_CNT_EN is defined.
`ifdef FF_SEQ_PERF_CNT_EN
module ff_seq_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        en,
  output logic [31:0] count
);

  // The layer-0 launch cycle itself is counted, so a restart loads 1 rather than 0.
  always_ff @(posedge clk) begin
    if (rst || clear)                    count <= '0;
    else if (load)                       count <= 32'd1;
    else if (en && count != '1)          count <= count + 32'd1;
  end

endmodule
`endif

// File: rtl/ff_layer_sequencer.sv
// Runs an N-layer feed-forward pass on one shared layer engine, one layer at a time.
// Optional cycle counter enabled by defining FF_SEQ_PERF_CNT_EN.
module ff_layer_sequencer
  import ff_seq_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_LAYERS    = 3,
  // Entry 0 (LSBs) is the input node count, entry k the output count of layer k.
  parameter logic [(NUM_LAYERS+1)*ADDRESS_WIDTH-1:0] LAYER_SIZES = {5'd2, 5'd5, 5'd5, 5'd3},
  parameter logic [NUM_LAYERS-1:0] ACT_MASK = 3'b011,
  parameter int BUF_W = $clog2(NUM_LAYERS+1)
) (
  input logic clk,
  input logic rst,
  ff_layer_sequencer_if.slave bus
);

  localparam logic [BUF_W-1:0] LAST_IDX = BUF_W'(NUM_LAYERS - 1);

  state_t                   state;
  logic [BUF_W-1:0]         idx;
  logic [BUF_W-1:0]         idx_n;
  logic                     pending;
  logic                     start_r;
  logic                     valid_r;
  logic [ADDRESS_WIDTH-1:0] num_in_r;
  logic [ADDRESS_WIDTH-1:0] num_out_r;
  logic                     act_r;
  logic [BUF_W-1:0]         dst_r;

  function automatic logic [ADDRESS_WIDTH-1:0] entry(input int i);
    return ADDRESS_WIDTH'(layer_size(SIZES_MAX_W'(LAYER_SIZES), i, ADDRESS_WIDTH));
  endfunction

  // Next layer index, so the layer fields can be registered in step with o_layer_start.
  always_comb begin
    idx_n = idx;
    if (rst || bus.i_abort) idx_n = '0;
    else begin
      case (state)
        S_NEXT:         idx_n = idx + 1'b1;
        S_IDLE, S_DONE: idx_n = '0;
        default:        idx_n = idx;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.i_abort) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      start_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      valid_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.i_valid) begin
          state   <= S_LAUNCH;
          start_r <= 1'b1;
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: if (bus.i_layer_done) begin
          if (idx == LAST_IDX) begin
            state   <= S_DONE;
            valid_r <= 1'b1;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          state   <= S_LAUNCH;
          start_r <= 1'b1;
        end
        // A request arriving in DONE is launched directly instead of being queued.
        S_DONE: if (pending || bus.i_valid) begin
          state   <= S_LAUNCH;
          start_r <= 1'b1;
        end else begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (state == S_DONE)                         pending <= 1'b0;
      else if (bus.i_valid && state != S_IDLE)     pending <= 1'b1;
    end
    idx       <= idx_n;
    num_in_r  <= entry(int'(idx_n));
    num_out_r <= entry(int'(idx_n) + 1);
    act_r     <= ACT_MASK[idx_n];
    dst_r     <= idx_n + 1'b1;
  end

  assign bus.o_ready       = !pending;
  assign bus.o_busy        = (state != S_IDLE);
  assign bus.o_layer_start = start_r;
  assign bus.o_layer_idx   = idx;
  assign bus.o_num_in      = num_in_r;
  assign bus.o_num_out     = num_out_r;
  assign bus.o_act_en      = act_r;
  assign bus.o_src_buf     = idx;
  assign bus.o_dst_buf     = dst_r;
  assign bus.o_valid       = valid_r;
  assign bus.dbg_state     = state;

`ifdef FF_SEQ_PERF_CNT_EN
  ff_seq_perf_counter u_perf (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.i_abort),
    .load  (state == S_LAUNCH && idx == '0),
    .en    (state != S_IDLE),
    .count (bus.o_cycle_count)
  );
`endif

endmodule

// File: tb/tb_ff_layer_sequencer.sv
// Directed bench for ff_layer_sequencer with a 4-cycle engine model.
`timescale 1ns/1ps
module tb_ff_layer_sequencer;
  import ff_seq_pkg::*;

  localparam int AW = 5;
  localparam int NL = 3;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ff_layer_sequencer_if #(.ADDRESS_WIDTH(AW), .BUF_W(BW)) bus ();

  ff_layer_sequencer #(
    .ADDRESS_WIDTH (AW),
    .NUM_LAYERS    (NL),
    .LAYER_SIZES   ({5'd2, 5'd5, 5'd5, 5'd3}),
    .ACT_MASK      (3'b011),
    .BUF_W         (BW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [BW-1:0] idx;
    logic [AW-1:0] nin;
    logic [AW-1:0] nout;
    logic          act;
    logic [BW-1:0] src;
    logic [BW-1:0] dst;
  } fields_t;

  typedef struct {
    int      start;
    fields_t f;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc;
  int last_start;
  logic engine_en;
  int vld_c[$], abort_c[$], done_c[$], rst_c[$];
  int start_obs[$], valid_obs[$];
  fields_t field_obs[$];
  logic obs_ready[64];
  logic obs_busy[64];
  logic [31:0] obs_cnt[64];

  function automatic bit has(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic cmp_q(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic cmp_fields(input string name, input int i, input fields_t e);
    fields_t g;
    g = '{default: '1};
    if (i < field_obs.size()) g = field_obs[i];
    check({name, "_idx"},  g.idx,  e.idx);
    check({name, "_nin"},  g.nin,  e.nin);
    check({name, "_nout"}, g.nout, e.nout);
    check({name, "_act"},  g.act,  e.act);
    check({name, "_src"},  g.src,  e.src);
    check({name, "_dst"},  g.dst,  e.dst);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_ready"}, bus.o_ready, 1);
    check({pfx, "_busy"},  bus.o_busy, 0);
    check({pfx, "_start"}, bus.o_layer_start, 0);
    check({pfx, "_valid"}, bus.o_valid, 0);
    check({pfx, "_idx"},   bus.o_layer_idx, 0);
    check({pfx, "_nin"},   bus.o_num_in, 3);
    check({pfx, "_nout"},  bus.o_num_out, 5);
    check({pfx, "_act"},   bus.o_act_en, 1);
    check({pfx, "_src"},   bus.o_src_buf, 0);
    check({pfx, "_dst"},   bus.o_dst_buf, 1);
    check({pfx, "_state"}, bus.dbg_state, S_IDLE);
`ifdef FF_SEQ_PERF_CNT_EN
    check({pfx, "_cnt"},   bus.o_cycle_count, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_layer_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    last_start = -100;
    engine_en = 1'b1;
    vld_c.delete(); abort_c.delete(); done_c.delete(); rst_c.delete();
    start_obs.delete(); valid_obs.delete(); field_obs.delete();
  endtask

  // One iteration per clock: observe outputs, then drive the inputs for this cycle.
  task automatic run(input int n);
    repeat (n) begin
      if (cyc < 64) begin
        obs_ready[cyc] = bus.o_ready;
        obs_busy[cyc]  = bus.o_busy;
`ifdef FF_SEQ_PERF_CNT_EN
        obs_cnt[cyc]   = bus.o_cycle_count;
`else
        obs_cnt[cyc]   = 32'd0;
`endif
      end
      if (bus.o_layer_start) begin
        start_obs.push_back(cyc);
        last_start = cyc;
        field_obs.push_back('{bus.o_layer_idx, bus.o_num_in, bus.o_num_out,
                              bus.o_act_en, bus.o_src_buf, bus.o_dst_buf});
      end
      if (bus.o_valid) valid_obs.push_back(cyc);
      bus.i_valid      = has(vld_c, cyc);
      bus.i_abort      = has(abort_c, cyc);
      bus.i_layer_done = (engine_en && cyc == last_start + 4) || has(done_c, cyc);
      rst              = has(rst_c, cyc);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_layer_done = 1'b0;
    rst = 1'b0;
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{1,  '{2'd0, 5'd3, 5'd5, 1'b1, 2'd0, 2'd1}};
    vecs[1] = '{7,  '{2'd1, 5'd5, 5'd5, 1'b1, 2'd1, 2'd2}};
    vecs[2] = '{13, '{2'd2, 5'd5, 5'd2, 1'b0, 2'd2, 2'd3}};

    // Single pass with the default configuration.
    do_reset();
    check_reset("reset");
    vld_c = '{0};
    run(26);
    check("s1_start_count", start_obs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("s1_start_cycle", (i < start_obs.size()) ? start_obs[i] : -1, vecs[i].start);
      cmp_fields("s1_layer", i, vecs[i].f);
    end
    cmp_q("s1_valid", valid_obs, '{18});
    check("s1_busy_after", obs_busy[19], 0);
`ifdef FF_SEQ_PERF_CNT_EN
    check("s1_cnt_after", obs_cnt[19], 18);
    check("s1_cnt_held", obs_cnt[25], 18);
`endif

    // Queued second request, third request dropped while pending.
    do_reset();
    vld_c = '{0, 8, 10};
    run(45);
    check("s2_ready_pending", obs_ready[9], 0);
    check("s2_ready_drop", obs_ready[11], 0);
    check("s2_ready_relaunch", obs_ready[19], 1);
    cmp_q("s2_start", start_obs, '{1, 7, 13, 19, 25, 31});
    cmp_q("s2_valid", valid_obs, '{18, 36});
    cmp_fields("s2_relaunch", 3, vecs[0].f);

    // Abort during layer-1 wait with a request pending; stray done pulses ignored.
    do_reset();
    vld_c   = '{0, 8};
    abort_c = '{9};
    done_c  = '{14, 20};
    run(10);
    check("s3_busy", bus.o_busy, 0);
    check("s3_ready", bus.o_ready, 1);
    check("s3_state", bus.dbg_state, S_IDLE);
    check("s3_valid", bus.o_valid, 0);
    run(20);
    cmp_q("s3_start", start_obs, '{1, 7});
    check("s3_valid_count", valid_obs.size(), 0);
    check("s3_busy_late", obs_busy[29], 0);

    // Request and abort in the same idle cycle.
    do_reset();
    vld_c   = '{0};
    abort_c = '{0};
    run(1);
    check("s4_busy", bus.o_busy, 0);
    check("s4_start", bus.o_layer_start, 0);
    run(6);
    check("s4_start_count", start_obs.size(), 0);

    // Reset while in NEXT, then a clean pass.
    do_reset();
    vld_c = '{0, 10};
    rst_c = '{6};
    run(7);
    check("s5_busy_next", obs_busy[6], 1);
    check_reset("s5_mid");
    run(25);
    cmp_q("s5_start", start_obs, '{1, 11, 17, 23});
    cmp_q("s5_valid", valid_obs, '{28});
    cmp_fields("s5_layer2", 3, vecs[2].f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
